// File: rtl/carryskip_adder9_pkg.sv
// Shared constants for the registered 9-bit carry-skip adder.
// Optional signed-overflow flag is enabled with `define OVERFLOW_FLAG_EN.
package carryskip_adder9_pkg;

    localparam int unsigned WIDTH      = 9;
    localparam int unsigned BLOCK_SIZE = 3;

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_LOAD_A  = 2'b01;
    localparam logic [1:0] CMD_LOAD_B  = 2'b10;
    localparam logic [1:0] CMD_COMPUTE = 2'b11;

    localparam int unsigned SUM8_BIT  = 7;
    localparam int unsigned COUT_BIT  = 6;
    localparam int unsigned VALID_BIT = 5;
    localparam int unsigned OVF_BIT   = 4;

endpackage

// File: rtl/carryskip_adder9_block.sv
// One carry-skip block: BLOCK_SIZE-bit ripple adder whose carry-out bypasses
// the ripple chain when every bit position propagates.
module carryskip_block #(
    parameter int unsigned BLOCK_SIZE = 3
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  c_in,
    output logic [BLOCK_SIZE-1:0] sum,
    output logic                  propagate,
    output logic                  c_out
);

    logic [BLOCK_SIZE-1:0] p;
    logic                  ripple;

    assign p = a ^ b;

    always_comb begin
        sum    = '0;
        ripple = c_in;
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            sum[i] = p[i] ^ ripple;
            ripple = (a[i] & b[i]) | (p[i] & ripple);
        end
    end

    assign propagate = &p;
    assign c_out     = propagate ? c_in : ripple;

endmodule

// File: rtl/carryskip_adder9.sv
// Registered 9-bit carry-skip adder behind the 8/8/8 pin wrapper.
// Optional signed-overflow flag on uio_out[4] when OVERFLOW_FLAG_EN is defined.
module carryskip_adder9
    import carryskip_adder9_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = carryskip_adder9_pkg::BLOCK_SIZE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned NBLK = WIDTH / BLOCK_SIZE;

    logic [1:0]       cmd;
    logic [WIDTH-1:0] operand;
    logic             cin;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q, valid_q, ovf_q;

    logic [WIDTH-1:0] core_sum;
    logic [NBLK:0]    carry;
    logic [NBLK-1:0]  blk_prop;
    logic             unused_ok;

    assign cmd     = uio_in[1:0];
    assign operand = {uio_in[2], ui_in};
    assign cin     = uio_in[3];

    assign carry[0] = cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        carryskip_block #(.BLOCK_SIZE(BLOCK_SIZE)) u_blk (
            .a         (a_q[g*BLOCK_SIZE +: BLOCK_SIZE]),
            .b         (b_q[g*BLOCK_SIZE +: BLOCK_SIZE]),
            .c_in      (carry[g]),
            .sum       (core_sum[g*BLOCK_SIZE +: BLOCK_SIZE]),
            .propagate (blk_prop[g]),
            .c_out     (carry[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (ena) begin
            case (cmd)
                CMD_LOAD_A: begin
                    a_q     <= operand;
                    valid_q <= 1'b0;
                end
                CMD_LOAD_B: begin
                    b_q     <= operand;
                    valid_q <= 1'b0;
                end
                CMD_COMPUTE: begin
                    sum_q   <= core_sum;
                    cout_q  <= carry[NBLK];
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef OVERFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (ena && cmd == CMD_COMPUTE)
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (core_sum[WIDTH-1] != a_q[WIDTH-1]);
    end
    assign uio_oe = 8'b1111_0000;
`else
    assign ovf_q  = 1'b0;
    assign uio_oe = 8'b1110_0000;
`endif

    always_comb begin
        uio_out            = '0;
        uio_out[SUM8_BIT]  = sum_q[WIDTH-1];
        uio_out[COUT_BIT]  = cout_q;
        uio_out[VALID_BIT] = valid_q;
        uio_out[OVF_BIT]   = ovf_q;
    end

    assign uo_out    = sum_q[7:0];
    assign unused_ok = &{1'b0, uio_in[7:4], blk_prop};

endmodule

// File: tb/tb_carryskip_adder9.sv
// Directed and randomised checks for carryskip_adder9 through its pin wrapper.
module tb_carryskip_adder9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef OVERFLOW_FLAG_EN
    logic       ovf_en = 1'b1;
    logic [7:0] oe_exp = 8'hF0;
`else
    logic       ovf_en = 1'b0;
    logic [7:0] oe_exp = 8'hE0;
`endif

    carryskip_adder9 #(.BLOCK_SIZE(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] cmd, input logic [8:0] d, input logic c);
        @(negedge clk);
        ui_in  = d[7:0];
        uio_in = {4'h0, c, d[8], cmd};
        @(posedge clk);
        #1;
        uio_in[1:0] = 2'b00;
    endtask

    // result-flag byte expected on uio_out after a COMPUTE
    function automatic logic [7:0] flags(input logic s8, input logic co, input logic ov);
        return {s8, co, 1'b1, ov & ovf_en, 4'h0};
    endfunction

    task automatic add(input logic [8:0] a, input logic [8:0] b, input logic c,
                       input logic [8:0] s, input logic co, input logic ov, input string tag);
        do_cmd(2'b01, a, 1'b0);
        do_cmd(2'b10, b, 1'b0);
        do_cmd(2'b11, 9'h000, c);
        check({tag, "_uo"}, {8'h0, uo_out}, {8'h0, s[7:0]});
        check({tag, "_uio"}, {8'h0, uio_out}, {8'h0, flags(s[8], co, ov)});
    endtask

    initial begin
        logic [8:0] ra, rb;
        logic       rc, rov;
        logic [9:0] ref_sum;

        repeat (3) @(posedge clk);
        #1;
        check("rst_uo", {8'h0, uo_out}, 16'h0000);
        check("rst_uio", {8'h0, uio_out}, 16'h0000);
        check("uio_oe", {8'h0, uio_oe}, {8'h0, oe_exp});
        @(negedge clk);
        rst_n = 1'b1;

        add(9'h012, 9'h034, 1'b0, 9'h046, 1'b0, 1'b0, "basic");
        do_cmd(2'b01, 9'h000, 1'b0);
        check("loada_clr_valid", {8'h0, uio_out}, 16'h0000);
        check("loada_hold_sum", {8'h0, uo_out}, 16'h0046);

        add(9'h155, 9'h0AA, 1'b1, 9'h000, 1'b1, 1'b0, "skip");
        add(9'h1FF, 9'h1FF, 1'b1, 9'h1FF, 1'b1, 1'b0, "wrap");

        do_cmd(2'b11, 9'h000, 1'b0);
        check("b2b_uo", {8'h0, uo_out}, 16'h00FE);
        check("b2b_uio", {8'h0, uio_out}, {8'h0, flags(1'b1, 1'b1, 1'b0)});

        ena = 1'b0;
        do_cmd(2'b01, 9'h0AA, 1'b0);
        do_cmd(2'b11, 9'h000, 1'b1);
        check("ena0_uo", {8'h0, uo_out}, 16'h00FE);
        check("ena0_uio", {8'h0, uio_out}, {8'h0, flags(1'b1, 1'b1, 1'b0)});
        ena = 1'b1;
        do_cmd(2'b00, 9'h000, 1'b0);
        check("ena1_hold_uo", {8'h0, uo_out}, 16'h00FE);
        // A must still be 0x1FF: 0x1FF + 0x1FF + 0 = 0x3FE
        do_cmd(2'b11, 9'h000, 1'b0);
        check("ena1_recompute", {8'h0, uo_out}, 16'h00FE);

        add(9'h0FF, 9'h001, 1'b0, 9'h100, 1'b0, 1'b1, "ovf_pos");
        add(9'h100, 9'h1FF, 1'b0, 9'h0FF, 1'b1, 1'b1, "ovf_neg");
        add(9'h005, 9'h1FF, 1'b0, 9'h004, 1'b1, 1'b0, "no_ovf");

        // asynchronous reset mid-cycle with operands and result loaded
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_uo", {8'h0, uo_out}, 16'h0000);
        check("midrst_uio", {8'h0, uio_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(2'b11, 9'h000, 1'b0);
        check("postrst_uo", {8'h0, uo_out}, 16'h0000);
        check("postrst_uio", {8'h0, uio_out}, {8'h0, flags(1'b0, 1'b0, 1'b0)});

        for (int i = 0; i < 10000; i++) begin
            ra = 9'($urandom_range(511));
            rb = 9'($urandom_range(511));
            rc = 1'($urandom_range(1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {9'h0, rc};
            rov = (ra[8] == rb[8]) && (ref_sum[8] != ra[8]);
            add(ra, rb, rc, ref_sum[8:0], ref_sum[9], rov, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
